// File: rtl/alu_seq_pkg.sv
// Shared opcode definitions and control state type for the sequential ALU
// and its control decoder.
package alu_seq_pkg;

  localparam logic [5:0] OPR_ADD   = 6'b100000;
  localparam logic [5:0] OPR_SUB   = 6'b100010;
  localparam logic [5:0] OPR_AND   = 6'b100100;
  localparam logic [5:0] OPR_OR    = 6'b100101;
  localparam logic [5:0] OPR_SLT   = 6'b101010;
  localparam logic [5:0] OPR_MULTU = 6'b011001;
  localparam logic [5:0] OPR_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic op_is_iter(input logic [5:0] op);
    return (op == OPR_MULTU) || (op == OPR_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Width-cycle iterative core: unsigned shift-add multiply and restoring divide.
// hi/lo hold product high/low or remainder/quotient once done pulses.
module alu_muldiv_iter
  import alu_seq_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [Width-1:0] hi,
  output logic [Width-1:0] lo,
  output logic             div0
);

  localparam int unsigned CW = $clog2(Width) + 1;
  localparam logic [CW-1:0] LAST = CW'(Width - 1);

  logic [Width-1:0] b_r;
  logic             div_r;
  logic [CW-1:0]    cnt;

  logic [Width-1:0] cur_hi, cur_lo, cur_b, nxt_hi, nxt_lo;
  logic             cur_div;
  logic [Width:0]   msum, shifted, diff;

  // The first iteration runs on the accept edge straight from the inputs, so
  // the last one lands Width-1 edges later and the result is ready for the
  // caller to register on the following edge.
  always_comb begin
    cur_hi  = start ? '0     : hi;
    cur_lo  = start ? a      : lo;
    cur_b   = start ? b      : b_r;
    cur_div = start ? is_div : div_r;
    msum    = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_b} : '0);
    shifted = {cur_hi, cur_lo[Width-1]};
    diff    = shifted - {1'b0, cur_b};
    nxt_hi  = msum[Width:1];
    nxt_lo  = {msum[0], cur_lo[Width-1:1]};
    if (cur_div) begin
      // A zero divisor always "fits": quotient fills with ones, remainder ends as a.
      if (shifted >= {1'b0, cur_b}) begin
        nxt_hi = diff[Width-1:0];
        nxt_lo = {cur_lo[Width-2:0], 1'b1};
      end else begin
        nxt_hi = shifted[Width-1:0];
        nxt_lo = {cur_lo[Width-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi    <= '0;
      lo    <= '0;
      b_r   <= '0;
      div_r <= 1'b0;
      div0  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        hi    <= nxt_hi;
        lo    <= nxt_lo;
        b_r   <= b;
        div_r <= is_div;
        div0  <= is_div && (b == '0);
        busy  <= 1'b1;
        cnt   <= CW'(1);
      end else if (busy) begin
        hi  <= nxt_hi;
        lo  <= nxt_lo;
        cnt <= cnt + CW'(1);
        if (cnt == LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
          cnt  <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute-stage ALU: handshake FSM, single-cycle ops and
// registered result/flags; MULTU/DIVU are delegated to alu_muldiv_iter.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in1,
  input  logic [Width-1:0] in2,
  input  logic [5:0]       aluop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out,
  output logic [Width-1:0] out_hi,
  output logic             zero,
  output logic             div0,
  output logic             illegal
);

  state_t           state, state_nx;
  logic             start, load_single, load_iter;
  logic [Width-1:0] s_res;
  logic             s_ill;
  logic             core_busy, core_done, core_div0;
  logic [Width-1:0] core_hi, core_lo;

  always_comb begin
    s_res = '0;
    s_ill = 1'b0;
    case (aluop)
      OPR_ADD: s_res = in1 + in2;
      OPR_SUB: s_res = in1 - in2;
      OPR_AND: s_res = in1 & in2;
      OPR_OR:  s_res = in1 | in2;
      OPR_SLT: s_res[0] = $signed(in1) < $signed(in2);
      OPR_MULTU, OPR_DIVU: s_res = '0;
      default: s_ill = 1'b1;
    endcase
  end

  assign in_ready  = (state == S_IDLE) && !core_busy;
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    start       = 1'b0;
    load_single = 1'b0;
    load_iter   = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          if (op_is_iter(aluop)) begin
            start    = 1'b1;
            state_nx = S_CALC;
          end else begin
            load_single = 1'b1;
            state_nx    = S_DONE;
          end
        end
      end
      S_CALC: begin
        if (core_done) begin
          load_iter = 1'b1;
          state_nx  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  alu_muldiv_iter #(.Width(Width)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .is_div (aluop == OPR_DIVU),
    .a      (in1),
    .b      (in2),
    .busy   (core_busy),
    .done   (core_done),
    .hi     (core_hi),
    .lo     (core_lo),
    .div0   (core_div0)
  );

  // Results persist through IDLE and only change when the next result loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out     <= '0;
      out_hi  <= '0;
      zero    <= 1'b0;
      div0    <= 1'b0;
      illegal <= 1'b0;
    end else if (load_single) begin
      out     <= s_res;
      out_hi  <= '0;
      zero    <= (s_res == '0);
      div0    <= 1'b0;
      illegal <= s_ill;
    end else if (load_iter) begin
      out     <= core_lo;
      out_hi  <= core_hi;
      zero    <= (core_lo == '0);
      div0    <= core_div0;
      illegal <= 1'b0;
    end
  end

endmodule
